// File: rtl/ultrascan_pkg.sv
// Shared types and constants for the ultrascan report collector.
package ultrascan_pkg;

  localparam int unsigned DROP_CNT_W    = 16;
  localparam int unsigned DEF_N_REPORTS = 2;
  localparam int unsigned DEF_OFFSET_W  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StActive,
    StDrain,
    StTerm,
    StFlush,
    StDone
  } state_e;

  // Record layout at the default widths; other widths use the same {last, offset, vector} order.
  typedef struct packed {
    logic                     last;
    logic [DEF_OFFSET_W-1:0]  offset;
    logic [DEF_N_REPORTS-1:0] vector;
  } rec_t;

  function automatic int unsigned rec_width(input int unsigned offset_w,
                                            input int unsigned n_reports);
    return 1 + offset_w + n_reports;
  endfunction

endpackage

// File: rtl/ultrascan_sync_fifo.sv
// Synchronous FIFO with registered storage; head entry is presented whenever non-empty.
module ultrascan_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FullCnt);
  assign do_pop   = pop && !empty;
  // A same-cycle pop frees the slot the push lands in.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rptr_q];

  // Storage write; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/ultrascan_report_collector.sv
// Converts automaton report wires into timestamped records and closes each scan with a terminator.
module ultrascan_report_collector
  import ultrascan_pkg::*;
#(
  parameter int unsigned N_REPORTS      = 2,
  parameter int unsigned OFFSET_W       = 32,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned REPORT_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [N_REPORTS-1:0]          report_bits,
  input  logic                          end_of_scan,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [N_REPORTS+OFFSET_W:0]   rec_data,
  output logic                          overflow,
  output logic [DROP_CNT_W-1:0]         drop_count,
  output logic                          done
);

  localparam int unsigned REC_W = rec_width(OFFSET_W, N_REPORTS);
  localparam int unsigned LAT_W = $clog2(REPORT_LATENCY + 1);

  state_e               state_q, state_d;
  logic [LAT_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [OFFSET_W-1:0]  offset_q;
  logic                 run_pipe_q [REPORT_LATENCY];
  logic [OFFSET_W-1:0]  off_pipe_q [REPORT_LATENCY];
  logic                 overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  logic             accept_run, capture, term_push, push, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [REC_W-1:0] push_data;

  // Symbols are only counted before the scan is closed.
  assign accept_run = run && (state_q == StIdle || state_q == StActive);
  assign capture    = (state_q == StIdle || state_q == StActive || state_q == StDrain) &&
                      run_pipe_q[REPORT_LATENCY-1] && (report_bits != '0);
  assign pop        = rec_valid && rec_ready;
  assign term_push  = (state_q == StTerm) && (!fifo_full || pop);
  assign push       = capture || term_push;
  assign drop       = capture && fifo_full && !pop;
  assign push_data  = term_push ? {1'b1, offset_q, {N_REPORTS{1'b0}}}
                                : {1'b0, off_pipe_q[REPORT_LATENCY-1], report_bits};

  assign rec_valid  = !fifo_empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
  assign done       = (state_q == StDone);

  ultrascan_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (rec_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Offset counter and the {run, offset} alignment pipe matching report latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q <= '0;
      for (int i = 0; i < REPORT_LATENCY; i++) begin
        run_pipe_q[i] <= 1'b0;
        off_pipe_q[i] <= '0;
      end
    end else begin
      if (accept_run) offset_q <= offset_q + OFFSET_W'(1);
      run_pipe_q[0] <= accept_run;
      off_pipe_q[0] <= offset_q;
      for (int i = 1; i < REPORT_LATENCY; i++) begin
        run_pipe_q[i] <= run_pipe_q[i-1];
        off_pipe_q[i] <= off_pipe_q[i-1];
      end
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (end_of_scan) begin
          state_d     = StDrain;
          drain_cnt_d = LAT_W'(REPORT_LATENCY);
        end else if (run) begin
          state_d = StActive;
        end
      end
      StActive: begin
        if (end_of_scan) begin
          state_d     = StDrain;
          drain_cnt_d = LAT_W'(REPORT_LATENCY);
        end
      end
      StDrain: begin
        // The last in-flight report is captured in the cycle the count leaves 1.
        drain_cnt_d = drain_cnt_q - LAT_W'(1);
        if (drain_cnt_q <= LAT_W'(1)) state_d = StTerm;
      end
      StTerm:  if (term_push) state_d = StFlush;
      StFlush: if (pop && rec_data[REC_W-1]) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ultrascan_report_collector.sv
// Directed bench for the report collector with hand-computed expected records.
module tb_ultrascan_report_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [1:0]  report_bits;
  logic        end_of_scan;
  logic        rec_valid;
  logic        rec_ready;
  logic [34:0] rec_data;
  logic        overflow;
  logic [15:0] drop_count;
  logic        done;

  int n_vec  = 0;
  int n_fail = 0;
  logic [34:0] got_q[$];

  always #5 clk = ~clk;

  ultrascan_report_collector #(
    .N_REPORTS      (2),
    .OFFSET_W       (32),
    .FIFO_DEPTH     (16),
    .REPORT_LATENCY (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .report_bits (report_bits),
    .end_of_scan (end_of_scan),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_data    (rec_data),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .done        (done)
  );

  function automatic logic [34:0] mk(input logic l, input logic [31:0] o, input logic [1:0] v);
    return {l, o, v};
  endfunction

  // Drive one cycle of inputs, log any transfer, advance to just after the next edge.
  task automatic cycle(input logic r, input logic [1:0] rb, input logic eos, input logic rdy);
    run = r; report_bits = rb; end_of_scan = eos; rec_ready = rdy;
    if (rec_valid && rec_ready) got_q.push_back(rec_data);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && !done; i++) cycle(1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(1'b1, 2'b11, 1'b0, 1'b1);
    n_vec++; if (rec_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid got %b want 0", rec_valid); end
    n_vec++; if (overflow !== 1'b0) begin n_fail++;
      $display("FAIL reset_overflow got %b want 0", overflow); end
    n_vec++; if (drop_count !== 16'd0) begin n_fail++;
      $display("FAIL reset_drop got %0d want 0", drop_count); end
    n_vec++; if (done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [34:0] exp_q[$];
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, (i == 4) ? 2'b01 : 2'b00, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 1'b1, 1'b1);
    run_until_done(50);
    exp_q = '{mk(1'b0, 32'd3, 2'b01), mk(1'b1, 32'd10, 2'b00)};
    n_vec++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", done); end
    n_vec++; if (got_q.size() != exp_q.size()) begin n_fail++;
      $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL basic_rec%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    // Activity after completion must be ignored.
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b11, 1'b0, 1'b1);
    n_vec++; if (rec_valid !== 1'b0 || done !== 1'b1) begin n_fail++;
      $display("FAIL done_ignore got valid=%b done=%b want 0/1", rec_valid, done); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i <= 20; i++)
      cycle(i < 20, (i >= 1) ? 2'b11 : 2'b00, i == 19, 1'b0);
    n_vec++; if (drop_count !== 16'd4) begin n_fail++;
      $display("FAIL ovf_drop got %0d want 4", drop_count); end
    n_vec++; if (overflow !== 1'b1) begin n_fail++;
      $display("FAIL ovf_flag got %b want 1", overflow); end
    n_vec++; if (rec_valid !== 1'b1 || rec_data !== mk(1'b0, 32'd0, 2'b11)) begin n_fail++;
      $display("FAIL ovf_head got %b/%h want 1/%h", rec_valid, rec_data, mk(1'b0, 32'd0, 2'b11)); end
    run_until_done(100);
    n_vec++; if (got_q.size() != 17) begin n_fail++;
      $display("FAIL ovf_count got %0d want 17", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== mk(1'b0, i, 2'b11)) begin n_fail++;
        $display("FAIL ovf_rec%0d got %h want %h", i, got_q[i], mk(1'b0, i, 2'b11)); end
    end
    if (got_q.size() == 17) begin
      n_vec++; if (got_q[16] !== mk(1'b1, 32'd20, 2'b00)) begin n_fail++;
        $display("FAIL ovf_term got %h want %h", got_q[16], mk(1'b1, 32'd20, 2'b00)); end
    end
    n_vec++; if (overflow !== 1'b1 || drop_count !== 16'd4) begin n_fail++;
      $display("FAIL ovf_sticky got %b/%0d want 1/4", overflow, drop_count); end
  endtask

  task automatic test_pop_on_full();
    do_reset();
    for (int i = 0; i <= 17; i++)
      cycle(i < 17, (i >= 1) ? 2'b01 : 2'b00, i == 16, i == 17);
    n_vec++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin n_fail++;
      $display("FAIL popfull_drop got %0d/%b want 0/0", drop_count, overflow); end
    run_until_done(100);
    n_vec++; if (got_q.size() != 18) begin n_fail++;
      $display("FAIL popfull_count got %0d want 18", got_q.size()); end
    for (int i = 0; i < 17 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== mk(1'b0, i, 2'b01)) begin n_fail++;
        $display("FAIL popfull_rec%0d got %h want %h", i, got_q[i], mk(1'b0, i, 2'b01)); end
    end
    if (got_q.size() == 18) begin
      n_vec++; if (got_q[17] !== mk(1'b1, 32'd17, 2'b00)) begin n_fail++;
        $display("FAIL popfull_term got %h want %h", got_q[17], mk(1'b1, 32'd17, 2'b00)); end
    end
  endtask

  task automatic test_random_ready();
    logic [34:0] exp_q[$];
    logic [1:0]  rb;
    logic        rdy, hold;
    logic [34:0] hold_d;
    hold = 1'b0;
    hold_d = '0;
    do_reset();
    for (int i = 0; i < 300 && !done; i++) begin
      if (hold) begin
        n_vec++; if (rec_valid !== 1'b1 || rec_data !== hold_d) begin n_fail++;
          $display("FAIL rnd_stable cyc%0d got %b/%h want 1/%h", i, rec_valid, rec_data, hold_d);
        end
      end
      case (i)
        1:       rb = 2'b01;
        4:       rb = 2'b10;
        7:       rb = 2'b11;
        10:      rb = 2'b01;
        11:      rb = 2'b10;
        default: rb = 2'b00;
      endcase
      rdy    = 1'($urandom_range(0, 1));
      hold   = rec_valid && !rdy;
      hold_d = rec_data;
      cycle(i < 12, rb, i == 12, rdy);
    end
    exp_q = '{mk(1'b0, 32'd0, 2'b01), mk(1'b0, 32'd3, 2'b10), mk(1'b0, 32'd6, 2'b11),
              mk(1'b0, 32'd9, 2'b01), mk(1'b0, 32'd10, 2'b10), mk(1'b1, 32'd12, 2'b00)};
    n_vec++; if (done !== 1'b1) begin n_fail++; $display("FAIL rnd_done got %b want 1", done); end
    n_vec++; if (got_q.size() != exp_q.size()) begin n_fail++;
      $display("FAIL rnd_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL rnd_rec%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_last_symbol();
    do_reset();
    for (int i = 0; i <= 8; i++) cycle(i < 8, (i == 8) ? 2'b10 : 2'b00, i == 7, 1'b1);
    run_until_done(50);
    n_vec++; if (got_q.size() != 2) begin n_fail++;
      $display("FAIL last_count got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_vec++; if (got_q[0] !== mk(1'b0, 32'd7, 2'b10)) begin n_fail++;
        $display("FAIL last_rec got %h want %h", got_q[0], mk(1'b0, 32'd7, 2'b10)); end
      n_vec++; if (got_q[1] !== mk(1'b1, 32'd8, 2'b00)) begin n_fail++;
        $display("FAIL last_term got %h want %h", got_q[1], mk(1'b1, 32'd8, 2'b00)); end
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    for (int i = 0; i <= 5; i++)
      cycle(i < 5, (i >= 1) ? 2'b01 : 2'b00, i == 5, 1'b0);
    n_vec++; if (rec_valid !== 1'b1) begin n_fail++;
      $display("FAIL rstd_pre got %b want 1", rec_valid); end
    reset = 1'b1;
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    n_vec++; if (rec_valid !== 1'b0 || overflow !== 1'b0 || done !== 1'b0) begin n_fail++;
      $display("FAIL rstd_clear got v=%b o=%b d=%b want 0/0/0", rec_valid, overflow, done); end
    got_q.delete();
    for (int i = 0; i <= 3; i++) cycle(i < 3, (i == 1) ? 2'b11 : 2'b00, i == 3, 1'b1);
    run_until_done(50);
    n_vec++; if (got_q.size() != 2) begin n_fail++;
      $display("FAIL rstd_count got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_vec++; if (got_q[0] !== mk(1'b0, 32'd0, 2'b11)) begin n_fail++;
        $display("FAIL rstd_rec got %h want %h", got_q[0], mk(1'b0, 32'd0, 2'b11)); end
      n_vec++; if (got_q[1] !== mk(1'b1, 32'd3, 2'b00)) begin n_fail++;
        $display("FAIL rstd_term got %h want %h", got_q[1], mk(1'b1, 32'd3, 2'b00)); end
    end
  endtask

  task automatic test_zero_length();
    do_reset();
    cycle(1'b0, 2'b00, 1'b1, 1'b1);
    run_until_done(50);
    n_vec++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
    n_vec++; if (got_q.size() != 1) begin n_fail++;
      $display("FAIL zero_count got %0d want 1", got_q.size()); end
    if (got_q.size() == 1) begin
      n_vec++; if (got_q[0] !== mk(1'b1, 32'd0, 2'b00)) begin n_fail++;
        $display("FAIL zero_term got %h want %h", got_q[0], mk(1'b1, 32'd0, 2'b00)); end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; report_bits = 2'b00; end_of_scan = 1'b0; rec_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_pop_on_full();
    test_random_ready();
    test_last_symbol();
    test_reset_in_drain();
    test_zero_length();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ultrascan_report_collector.md
Name: ultrascan_report_collector

Overview:
Sits downstream of an Automata_* instance. It turns the per-cycle report wires (active_state of the report STEs) into timestamped report records. Records are buffered in a small FIFO and drained to the host-side writer over a valid/ready stream. This is the consuming end of the automaton report interface: the automaton drives the symbols and run that produce reports, and this block records and ships them. It closes every scan with a terminator record.

Parameters:
N_REPORTS, 2, number of report wires from the automaton (one bit each)
OFFSET_W, 32, width of the symbol-offset counter
FIFO_DEPTH, 16, record FIFO entries (power of 2, >=2)
REPORT_LATENCY, 1, cycles from a symbol being consumed (run=1) to its report bits being valid

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high; same reset as the automaton
run  in  1  automaton consumed one symbol this cycle
report_bits  in  N_REPORTS  automaton report outputs, e.g. {w_out_6, w_out_4}
end_of_scan  in  1  one-cycle pulse; the last symbol has been issued
rec_valid  out  1  record available
rec_ready  in  1  downstream accepts the record
rec_data  out  1+OFFSET_W+N_REPORTS  {last, offset, report_vector}
overflow  out  1  sticky; a record was dropped because the FIFO was full
drop_count  out  16  number of dropped records, saturating at 0xFFFF
done  out  1  terminator record accepted; scan complete

Behaviour:
- Reset: all outputs 0, FIFO empty, offset counter 0, FSM in IDLE. Reset mid-scan discards FIFO contents and any in-flight report.
- Offset counter: increments by 1 on every cycle with run=1 and wraps modulo 2^OFFSET_W without flagging.
- Offset alignment: a REPORT_LATENCY-deep shift register carries {run, offset} so that each report is tagged with the offset of the symbol that caused it. The first symbol after reset has offset 0.
- Capture: when the delayed run is 1 and report_bits != 0, push {0, delayed_offset, report_bits}. All-zero report vectors are never pushed.
- FIFO full on a capture: drop the record, set overflow (sticky until reset), and increment drop_count (saturating). A pop in the same cycle frees a slot first, so no drop occurs when FIFO is full but rec_valid&&rec_ready.
- Simultaneous push and pop: occupancy is unchanged. The FIFO uses registered storage; the first record reaches the output one cycle after its push, with rec_valid asserted in that cycle.
- Handshake: a transfer occurs when rec_valid&&rec_ready. While rec_valid=1, rec_data must stay stable until the transfer. rec_valid must not depend combinationally on rec_ready.
- FSM:
  - IDLE: enter ACTIVE on the first run=1.
  - ACTIVE: capture reports. end_of_scan moves to DRAIN and loads drain_cnt=REPORT_LATENCY.
  - DRAIN: keep capturing in-flight reports and decrement drain_cnt. At 0, move to TERM.
  - TERM: push terminator {1, total_symbols (offset counter), 0} once a FIFO slot is free. The terminator is never dropped; it waits for a slot. Go to FLUSH.
  - FLUSH: move to DONE when the terminator transfers.
  - DONE: done=1; ignore run and report_bits; stay until reset.
- end_of_scan in IDLE (zero-length scan): go directly to DRAIN. The terminator then carries offset 0.
- run and report captures are ignored in TERM, FLUSH and DONE. A run in those states is a protocol error; it is counted nowhere.

Decomposition:
- Shared package ultrascan_pkg:
  - rec_t packed struct {last, offset, vector} (widths from parameters via a localparam function or parameterized typedef macro)
  - collector FSM state enum (IDLE, ACTIVE, DRAIN, TERM, FLUSH, DONE)
  - DROP_CNT_W = 16
- One sub-module: ultrascan_sync_fifo (parameterized WIDTH/DEPTH, push/pop/full/empty, registered output). It is reusable for the symbol-feed side.

Test Plan:
- N_REPORTS=2, 10 runs, report_bits=2'b01 in the cycle after the run with offset 3 (REPORT_LATENCY=1), rec_ready=1 -> one record {0,3,01}; after end_of_scan, terminator {1,10,00}; done=1.
- Reports on offsets 0..19 every cycle, rec_ready=0 -> 16 records stored; overflow=1 and drop_count=4. Then rec_ready=1 -> offsets 0..15 in order, then terminator {1,20,00}.
- FIFO full, and a capture coincides with a pop -> no drop; drop_count unchanged; order preserved.
- rec_ready toggled pseudo-randomly -> rec_data stable while rec_valid&&!rec_ready; no duplicate or lost records versus the reference model.
- Report on the very last symbol (offset 7), end_of_scan pulsed the same cycle -> record {0,7,xx} appears before the terminator {1,8,00}.
- reset asserted while in DRAIN with 5 records queued -> next cycle rec_valid=0, overflow=0, done=0. A new scan starts at offset 0.
